seri_verici_param: RTL and testbench

- Parametrised successor of the lab-4 5-bit parallel-to-serial transmitter.
- Loads an N-bit word on `baslat` and sends it on `y` as a framed serial stream: start bit, N data bits, optional parity bit, stop bit.
- Adds over the lab-4 block: configurable bit order, bit period gated by `en`, a done pulse, and a collision flag.
- Sits between a parallel data source and a single-wire serial link.

---
 rtl/seri_verici_param_pkg.sv | 30 +++
 rtl/seri_verici_param_bit_zamanlayici.sv | 30 +++
 rtl/seri_verici_param.sv | 153 +++++++++++++++
 tb/tb_seri_verici_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seri_verici_param_pkg.sv
// Shared types and helpers for the parametrised serial transmitter.
package seri_verici_pkg;

  // Frame states: idle, start bit, data bits, parity bit, stop bit.
  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    BASLA  = 3'd1,
    VERI   = 3'd2,
    PARITE = 3'd3,
    DUR    = 3'd4
  } durum_t;

  // Default geometry, mirrored by the top-level parameter defaults.
  localparam int VARSAYILAN_N   = 5;
  localparam int VARSAYILAN_DIV = 1;

  // Counter width that never collapses to zero bits (DIV=1 or N=1).
  function automatic int sayac_genisligi(input int deger);
    return (deger <= 1) ? 1 : $clog2(deger);
  endfunction

  localparam int VARSAYILAN_DIV_W = sayac_genisligi(VARSAYILAN_DIV);
  localparam int VARSAYILAN_IDX_W = sayac_genisligi(VARSAYILAN_N);

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int cerceve_uzunlugu(input int n, input int parity_en);
    return n + 2 + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/seri_verici_param_bit_zamanlayici.sv
// Bit-period timer: counts en-qualified cycles and flags the last one of
// each DIV-long bit period. clr holds the count at zero while idle.
module bit_zamanlayici
  import seri_verici_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = sayac_genisligi(DIV);

  logic [W-1:0] r_sayac;
  logic         w_son;

  assign w_son = (r_sayac == W'(DIV - 1));
  assign tick  = en && w_son && !clr;

  // Wrapping period counter; frozen whenever en is low.
  always_ff @(posedge clk) begin
    if (!reset)      r_sayac <= '0;
    else if (clr)    r_sayac <= '0;
    else if (en)     r_sayac <= w_son ? '0 : r_sayac + W'(1);
  end

endmodule

// File: rtl/seri_verici_param.sv
// Parametrised framed parallel-to-serial transmitter:
// start(0), N data bits, optional parity, stop(1). All outputs registered.
module seri_verici_param
  import seri_verici_pkg::*;
#(
  parameter int N          = VARSAYILAN_N,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int DIV        = VARSAYILAN_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         baslat,
  input  logic [N-1:0] D,
  output logic         y,
  output logic         mesgul,
  output logic         bitti,
  output logic         hata
);

  localparam int IW = sayac_genisligi(N);

  durum_t         r_state, w_state_n;
  logic [N-1:0]   r_sr, w_sr_n;
  logic [IW-1:0]  r_idx, w_idx_n;
  logic           r_par, w_par_n;
  logic           r_y, w_y_n;
  logic           r_mesgul, w_mesgul_n;
  logic           r_bitti, w_bitti_n;
  logic           r_hata, w_hata_n;
  logic           w_tick;

  // Bit that goes on the line next, chosen by bit order.
  function automatic logic bas(input logic [N-1:0] v);
    return (MSB_FIRST != 0) ? v[N-1] : v[0];
  endfunction

  // Advance the shift register by one bit toward the line.
  function automatic logic [N-1:0] kaydir(input logic [N-1:0] v);
    return (MSB_FIRST != 0) ? {v[N-2:0], 1'b0} : {1'b0, v[N-1:1]};
  endfunction

  // Counter only runs while a frame is in flight.
  bit_zamanlayici #(.DIV(DIV)) u_zaman (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (r_state == BOSTA),
    .tick  (w_tick)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= BOSTA;
      r_sr     <= '0;
      r_idx    <= '0;
      r_par    <= 1'b0;
      r_y      <= 1'b1;
      r_mesgul <= 1'b0;
      r_bitti  <= 1'b0;
      r_hata   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sr     <= w_sr_n;
      r_idx    <= w_idx_n;
      r_par    <= w_par_n;
      r_y      <= w_y_n;
      r_mesgul <= w_mesgul_n;
      r_bitti  <= w_bitti_n;
      r_hata   <= w_hata_n;
    end
  end

  // Next-state and next-output logic; y is computed one edge ahead so the
  // line itself comes straight from a flop.
  always_comb begin
    w_state_n  = r_state;
    w_sr_n     = r_sr;
    w_idx_n    = r_idx;
    w_par_n    = r_par;
    w_y_n      = r_y;
    w_mesgul_n = r_mesgul;
    w_bitti_n  = 1'b0;
    // A start request during a frame is dropped but reported.
    w_hata_n   = baslat && r_mesgul;
    unique case (r_state)
      BOSTA: begin
        w_y_n      = 1'b1;
        w_mesgul_n = 1'b0;
        if (baslat) begin
          w_state_n  = BASLA;
          w_sr_n     = D;
          w_par_n    = (PARITY_ODD != 0) ? ~^D : ^D;
          w_idx_n    = '0;
          w_y_n      = 1'b0;
          w_mesgul_n = 1'b1;
        end
      end
      BASLA: begin
        if (w_tick) begin
          w_state_n = VERI;
          w_idx_n   = '0;
          w_y_n     = bas(r_sr);
        end
      end
      VERI: begin
        if (w_tick) begin
          if (r_idx == IW'(N - 1)) begin
            if (PARITY_EN != 0) begin
              w_state_n = PARITE;
              w_y_n     = r_par;
            end else begin
              w_state_n = DUR;
              w_y_n     = 1'b1;
            end
          end else begin
            w_sr_n  = kaydir(r_sr);
            w_idx_n = r_idx + IW'(1);
            w_y_n   = bas(kaydir(r_sr));
          end
        end
      end
      PARITE: begin
        if (w_tick) begin
          w_state_n = DUR;
          w_y_n     = 1'b1;
        end
      end
      DUR: begin
        w_y_n = 1'b1;
        if (w_tick) begin
          w_state_n  = BOSTA;
          w_mesgul_n = 1'b0;
          w_bitti_n  = 1'b1;
        end
      end
      default: begin
        w_state_n  = BOSTA;
        w_y_n      = 1'b1;
        w_mesgul_n = 1'b0;
      end
    endcase
  end

  assign y      = r_y;
  assign mesgul = r_mesgul;
  assign bitti  = r_bitti;
  assign hata   = r_hata;

endmodule

// File: tb/tb_seri_verici_param.sv
// Directed bench for seri_verici_param across several parameter sets.
module tb_seri_verici_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_a = 1'b1;
  logic en_b = 1'b1;
  logic b0 = 0, b1 = 0, b2 = 0, b3 = 0, b4 = 0;
  logic [4:0] D0 = '0, D1 = '0, D2 = '0, D3 = '0;
  logic [7:0] D4 = '0;
  logic y0, m0, f0, h0;
  logic y1, m1, f1, h1;
  logic y2, m2, f2, h2;
  logic y3, m3, f3, h3;
  logic y4, m4, f4, h4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Defaults: N=5, MSB first, no parity, DIV=1.
  seri_verici_param u0 (.clk(clk), .reset(reset), .en(en_a), .baslat(b0), .D(D0),
    .y(y0), .mesgul(m0), .bitti(f0), .hata(h0));
  // LSB first, even parity.
  seri_verici_param #(.MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk),
    .reset(reset), .en(en_a), .baslat(b1), .D(D1), .y(y1), .mesgul(m1), .bitti(f1), .hata(h1));
  // LSB first, odd parity.
  seri_verici_param #(.MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk),
    .reset(reset), .en(en_a), .baslat(b2), .D(D2), .y(y2), .mesgul(m2), .bitti(f2), .hata(h2));
  // Three en-ticks per bit.
  seri_verici_param #(.DIV(3)) u3 (.clk(clk), .reset(reset), .en(en_b), .baslat(b3),
    .D(D3), .y(y3), .mesgul(m3), .bitti(f3), .hata(h3));
  // N=8, MSB first, even parity.
  seri_verici_param #(.N(8), .PARITY_EN(1)) u4 (.clk(clk), .reset(reset), .en(en_a),
    .baslat(b4), .D(D4), .y(y4), .mesgul(m4), .bitti(f4), .hata(h4));

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++; if (y0 !== 1'b1) begin bad++; $display("FAIL reset_y got=%b exp=1", y0); end
    total++; if (m0 !== 1'b0) begin bad++; $display("FAIL reset_mesgul got=%b exp=0", m0); end
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL reset_bitti got=%b exp=0", f0); end
    total++; if (h0 !== 1'b0) begin bad++; $display("FAIL reset_hata got=%b exp=0", h0); end
    total++; if (y3 !== 1'b1 || m3 !== 1'b0) begin
      bad++; $display("FAIL reset_u3 got y=%b m=%b exp y=1 m=0", y3, m3); end
    reset = 1'b1;
    step();
    total++; if (y0 !== 1'b1 || m0 !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got y=%b m=%b exp y=1 m=0", y0, m0); end
  endtask

  task automatic test_default_frame();
    logic [7:0] ey;
    ey = 8'b0010_1011;  // cycle 0 is the MSB of this vector
    D0 = 5'b01010; b0 = 1'b1;
    step();
    b0 = 1'b0; D0 = 5'b10101;  // later D changes must not matter
    for (int i = 0; i < 8; i++) begin
      total++; if (y0 !== ey[7-i]) begin
        bad++; $display("FAIL def_y[%0d] got=%b exp=%b", i, y0, ey[7-i]); end
      total++; if (m0 !== (i < 7)) begin
        bad++; $display("FAIL def_mesgul[%0d] got=%b exp=%b", i, m0, (i < 7)); end
      total++; if (f0 !== (i == 7)) begin
        bad++; $display("FAIL def_bitti[%0d] got=%b exp=%b", i, f0, (i == 7)); end
      step();
    end
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL def_bitti_single got=%b exp=0", f0); end
  endtask

  task automatic test_parity_lsb();
    logic [8:0] ey1, ey2;
    ey1 = 9'b0_0110_1111;  // start, 0,1,1,0,1, parity 1, stop, idle
    ey2 = 9'b0_0110_1011;  // same data, parity 0
    D1 = 5'b10110; D2 = 5'b10110; b1 = 1'b1; b2 = 1'b1;
    step();
    b1 = 1'b0; b2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      total++; if (y1 !== ey1[8-i]) begin
        bad++; $display("FAIL even_y[%0d] got=%b exp=%b", i, y1, ey1[8-i]); end
      total++; if (y2 !== ey2[8-i]) begin
        bad++; $display("FAIL odd_y[%0d] got=%b exp=%b", i, y2, ey2[8-i]); end
      total++; if (m1 !== (i < 8)) begin
        bad++; $display("FAIL even_mesgul[%0d] got=%b exp=%b", i, m1, (i < 8)); end
      total++; if (f2 !== (i == 8)) begin
        bad++; $display("FAIL odd_bitti[%0d] got=%b exp=%b", i, f2, (i == 8)); end
      step();
    end
  endtask

  task automatic test_div_en();
    logic [6:0] ebit;
    ebit = 7'b0111_111;  // start then five ones then stop
    D3 = 5'b11111; b3 = 1'b1; en_b = 1'b1;
    step();
    b3 = 1'b0;
    for (int c = 0; c <= 42; c++) begin
      en_b = ((c % 2) == 1);
      if (c < 42) begin
        total++; if (y3 !== ebit[6 - c/6]) begin
          bad++; $display("FAIL div_y[%0d] got=%b exp=%b", c, y3, ebit[6 - c/6]); end
      end
      total++; if (m3 !== (c < 42)) begin
        bad++; $display("FAIL div_mesgul[%0d] got=%b exp=%b", c, m3, (c < 42)); end
      total++; if (f3 !== (c == 42)) begin
        bad++; $display("FAIL div_bitti[%0d] got=%b exp=%b", c, f3, (c == 42)); end
      step();
    end
    en_b = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ey, ez;
    ey = 8'b0010_1011;  // D=01010
    ez = 8'b0110_0111;  // D=11001
    D0 = 5'b01010; b0 = 1'b1;
    step();
    b0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (y0 !== ey[7-i]) begin
        bad++; $display("FAIL col_y[%0d] got=%b exp=%b", i, y0, ey[7-i]); end
      total++; if (h0 !== (i == 4)) begin
        bad++; $display("FAIL col_hata[%0d] got=%b exp=%b", i, h0, (i == 4)); end
      total++; if (f0 !== (i == 7)) begin
        bad++; $display("FAIL col_bitti[%0d] got=%b exp=%b", i, f0, (i == 7)); end
      b0 = (i == 3) || (i == 7);
      if (i == 7) D0 = 5'b11001;
      step();
      b0 = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      total++; if (y0 !== ez[7-i]) begin
        bad++; $display("FAIL b2b_y[%0d] got=%b exp=%b", i, y0, ez[7-i]); end
      total++; if (m0 !== (i < 7)) begin
        bad++; $display("FAIL b2b_mesgul[%0d] got=%b exp=%b", i, m0, (i < 7)); end
      total++; if (h0 !== 1'b0) begin
        bad++; $display("FAIL b2b_hata[%0d] got=%b exp=0", i, h0); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ez;
    logic seen;
    ez = 8'b0110_0111;
    D0 = 5'b01010; b0 = 1'b1;
    step();
    b0 = 1'b0;
    step(); step(); step();  // now in VERI
    reset = 1'b0;
    step();
    total++; if (y0 !== 1'b1 || m0 !== 1'b0 || f0 !== 1'b0) begin
      bad++; $display("FAIL mid_reset got y=%b m=%b f=%b exp y=1 m=0 f=0", y0, m0, f0); end
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (f0 === 1'b1 || m0 === 1'b1 || y0 !== 1'b1) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL post_reset_quiet got=%b exp=0", seen); end
    D0 = 5'b11001; b0 = 1'b1;
    step();
    b0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (y0 !== ez[7-i]) begin
        bad++; $display("FAIL rst_frame_y[%0d] got=%b exp=%b", i, y0, ez[7-i]); end
      total++; if (f0 !== (i == 7)) begin
        bad++; $display("FAIL rst_frame_bitti[%0d] got=%b exp=%b", i, f0, (i == 7)); end
      step();
    end
  endtask

  task automatic test_n8();
    logic [11:0] ey;
    ey = 12'b0101_0010_1011;  // start, A5 MSB first, parity 0, stop, idle
    D4 = 8'hA5; b4 = 1'b1;
    step();
    b4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      total++; if (y4 !== ey[11-i]) begin
        bad++; $display("FAIL n8_y[%0d] got=%b exp=%b", i, y4, ey[11-i]); end
      total++; if (m4 !== (i < 11)) begin
        bad++; $display("FAIL n8_mesgul[%0d] got=%b exp=%b", i, m4, (i < 11)); end
      total++; if (f4 !== (i == 11)) begin
        bad++; $display("FAIL n8_bitti[%0d] got=%b exp=%b", i, f4, (i == 11)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity_lsb();
    test_div_en();
    test_back_to_back();
    test_reset_mid();
    test_n8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
